// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS datapath.
// Holds the memory sequencer state encoding and load-width codes.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } memctrl_state_t;

  localparam logic [1:0] LB_WORD = 2'b00;
  localparam logic [1:0] LB_U    = 2'b01;
  localparam logic [1:0] LB_S    = 2'b10;

endpackage

// File: rtl/memctrl_byte_ext.sv
// Little-endian byte select with zero/sign extension for LBU/LB.
// Width code 2'b11 falls through to a plain word.
module byte_ext
  import mips_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  off,
  input  logic [1:0]  lb,
  output logic [31:0] ext
);

  logic [7:0] b;

  always_comb begin
    b = data[7:0];
    unique case (off)
      2'd0: b = data[7:0];
      2'd1: b = data[15:8];
      2'd2: b = data[23:16];
      2'd3: b = data[31:24];
      default: b = data[7:0];
    endcase
  end

  always_comb begin
    ext = data;
    unique case (lb)
      LB_U:    ext = {24'b0, b};
      LB_S:    ext = {{24{b[7]}}, b};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/memctrl.sv
// Memory access sequencer: strobes -> req/ack, stall, IR and MDR.
// Optional WAIT abort with sticky err under MEMCTRL_TIMEOUT_EN.
module memctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irwrite,
  input  logic        iord,
  input  logic        memwrite,
  input  logic [1:0]  lb,
  input  logic [31:0] pc,
  input  logic [31:0] aluout,
  input  logic [31:0] wd,
  output logic        stall,
  output logic [31:0] instr,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  memctrl_state_t state, next;

  logic        access;
  logic [31:0] addr_sel;
  logic [1:0]  off_q;
  logic [1:0]  lb_q;
  logic        dest_q;
  logic [31:0] ext;
  logic        tmo;
  logic        finish;

  assign access   = irwrite | iord;
  assign addr_sel = iord ? aluout : pc;
  assign finish   = (state == WAIT) & (mem_ack | tmo);

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int CL = $clog2(TIMEOUT + 1);
  localparam int CW = (CL < 8) ? 8 : CL;

  logic [CW-1:0] cnt;
  logic          err_q;

  assign tmo = (state == WAIT) & ~mem_ack
             & (cnt == CW'(TIMEOUT - 1));
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE)
        cnt <= '0;
      else if (state == WAIT)
        cnt <= cnt + 1'b1;
      if (tmo)
        err_q <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  byte_ext u_ext (
    .data (mem_rdata),
    .off  (off_q),
    .lb   (lb_q),
    .ext  (ext)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next;
  end

  always_comb begin
    next  = state;
    stall = 1'b0;
    unique case (state)
      IDLE: begin
        stall = access;
        if (access)
          next = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_ack | tmo)
          next = DONE;
      end
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      instr     <= '0;
      rdata     <= '0;
      off_q     <= '0;
      lb_q      <= LB_WORD;
      dest_q    <= 1'b0;
    end else begin
      if (state == IDLE && access) begin
        mem_req   <= 1'b1;
        mem_we    <= iord & memwrite;
        mem_addr  <= {addr_sel[31:2], 2'b00};
        mem_wdata <= wd;
        off_q     <= addr_sel[1:0];
        lb_q      <= lb;
        dest_q    <= iord;
      end
      if (finish) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        // an aborted read leaves zero in its destination
        if (!mem_we) begin
          if (dest_q)
            rdata <= mem_ack ? ext : 32'h0;
          else
            instr <= mem_ack ? mem_rdata : 32'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_memctrl.sv
// Scoreboard bench for memctrl: random accesses, variable-latency memory.
// Define MEMCTRL_TIMEOUT_EN to also exercise the WAIT abort path.
module tb_memctrl;

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk;
  logic        reset;
  logic        irwrite, iord, memwrite;
  logic [1:0]  lb;
  logic [31:0] pc, aluout, wd;
  logic        stall;
  logic [31:0] instr, rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;

  memctrl #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .irwrite   (irwrite),
    .iord      (iord),
    .memwrite  (memwrite),
    .lb        (lb),
    .pc        (pc),
    .aluout    (aluout),
    .wd        (wd),
    .stall     (stall),
    .instr     (instr),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic [31:0] rd;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] mdr;
    int          stl;
  } exp_t;

  req_t memq[$];
  exp_t sbq[$];

  int total = 0;
  int bad = 0;
  logic [31:0] ir_m = 0;
  logic [31:0] mdr_m = 0;
  bit stray_req = 0;
  bit stray_done = 0;

  task automatic check(string nm, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(
    logic [31:0] d, logic [31:0] a, logic [1:0] w);
    logic [31:0] b;
    b = (d >> (8 * (a % 4))) & 32'hFF;
    if (w == 2'd1) return b;
    if (w == 2'd2) return (b >= 128) ? (b | 32'hFFFFFF00) : b;
    return d;
  endfunction

  // memory model: pops one request descriptor per mem_req
  initial begin
    req_t r;
    bit ab;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        mem_ack = 1'b0;
      end else if (stray_req) begin
        stray_req = 0;
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        @(negedge clk); #1;
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (memq.size() == 0) begin
          check("memq_empty", 1, 0);
          r.lat = 1; r.rd = 0; r.addr = mem_addr;
          r.we = mem_we; r.wdata = mem_wdata;
        end else begin
          r = memq.pop_front();
        end
        check("mem_addr", mem_addr, r.addr);
        check("mem_we", mem_we, r.we);
        if (r.we) check("mem_wdata", mem_wdata, r.wdata);
        ab = 0;
        for (int i = 1; (i < r.lat || r.lat == 0) && i < 300; i++) begin
          @(negedge clk); #1;
          if (reset || !mem_req) begin
            ab = 1;
            break;
          end
          check("addr_hold", mem_addr, r.addr);
          check("we_hold", mem_we, r.we);
          if (r.we) check("wdata_hold", mem_wdata, r.wdata);
        end
        if (!ab && r.lat != 0) begin
          mem_ack = 1'b1;
          mem_rdata = r.rd;
          @(negedge clk); #1;
          if (stray_done) begin
            stray_done = 0;
            mem_rdata = $urandom;
            @(negedge clk); #1;
          end
          mem_ack = 1'b0;
        end
      end
    end
  end

  // monitor: each stall burst ends in DONE, where IR/MDR are compared
  initial begin
    int cnt;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        cnt = 0;
      end else if (stall) begin
        cnt++;
      end else if (cnt > 0) begin
        if (sbq.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("instr", instr, e.ir);
          check("rdata", rdata, e.mdr);
          check("stall_cycles", cnt, e.stl);
        end
        cnt = 0;
      end
    end
  end

  task automatic access(input bit irw, input bit io, input bit mw,
                        input logic [1:0] w, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] d,
                        input int lat, input logic [31:0] rd,
                        input bit sd);
    req_t r;
    exp_t e;
    logic [31:0] ad;
    int n;
    ad = io ? a : p;
    r.lat = lat;
    r.rd = rd;
    r.addr = ad & ~32'h3;
    r.we = io & mw;
    r.wdata = d;
    memq.push_back(r);
    if (!(io & mw)) begin
      if (io) mdr_m = (lat == 0) ? 32'h0 : ref_load(rd, ad, w);
      else ir_m = (lat == 0) ? 32'h0 : rd;
    end
    e.ir = ir_m;
    e.mdr = mdr_m;
    e.stl = (lat == 0) ? TMO + 1 : lat + 1;
    sbq.push_back(e);
    stray_done = sd;
    @(negedge clk);
    irwrite = irw; iord = io; memwrite = mw; lb = w;
    pc = p; aluout = a; wd = d;
    #1 check("stall_rise", stall, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 400);
    if (n >= 400) check("done_timeout", 0, 1);
    irwrite = 0; iord = 0; memwrite = 0;
  endtask

  task automatic stray_idle();
    stray_req = 1;
    repeat (3) @(negedge clk);
    #1;
    check("stray_instr", instr, ir_m);
    check("stray_rdata", rdata, mdr_m);
    check("stray_req", mem_req, 0);
    check("stray_stall", stall, 0);
  endtask

  task automatic reset_in_wait();
    req_t r;
    r.lat = 20; r.rd = 32'h1234_5678; r.we = 0; r.wdata = 0;
    r.addr = 32'h0000_0080;
    memq.push_back(r);
    @(negedge clk);
    irwrite = 1; pc = 32'h0000_0080;
    @(negedge clk);
    @(negedge clk);
    reset = 1; irwrite = 0;
    @(negedge clk); #1;
    check("rst_req", mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_instr", instr, 0);
    check("rst_rdata", rdata, 0);
    reset = 0;
    ir_m = 0;
    mdr_m = 0;
  endtask

  initial begin
    int op, n;
    logic [31:0] a, d;
    reset = 1; irwrite = 0; iord = 0; memwrite = 0; lb = 0;
    pc = 0; aluout = 0; wd = 0;
    repeat (3) @(negedge clk);
    #1;
    check("r_req", mem_req, 0);
    check("r_we", mem_we, 0);
    check("r_addr", mem_addr, 0);
    check("r_wdata", mem_wdata, 0);
    check("r_instr", instr, 0);
    check("r_rdata", rdata, 0);
    check("r_err", err, 0);
    check("r_stall", stall, 0);
    reset = 0;

    access(1, 0, 0, 2'b00, 32'h40, 0, 0, 1, 32'h20080005, 0);
    check("fetch_ir", instr, 32'h20080005);
    access(0, 1, 0, 2'b10, 0, 32'h103, 0, 1, 32'h80FFFFFF, 0);
    check("lb_103", rdata, 32'hFFFFFF80);
    access(0, 1, 0, 2'b01, 0, 32'h103, 0, 1, 32'h80FFFFFF, 0);
    check("lbu_103", rdata, 32'h00000080);
    access(0, 1, 0, 2'b10, 0, 32'h101, 0, 1, 32'h80FFFFFF, 0);
    check("lb_101", rdata, 32'hFFFFFFFF);
    access(0, 1, 1, 2'b00, 0, 32'h20, 32'hDEADBEEF, 4, 32'h5555, 0);
    check("sw_ir", instr, 32'h20080005);
    check("sw_mdr", rdata, 32'hFFFFFFFF);
    stray_idle();
    access(0, 1, 0, 2'b00, 0, 32'h44, 0, 2, 32'hCAFEF00D, 1);
    repeat (2) @(negedge clk);
    #1 check("stray_done_mdr", rdata, 32'hCAFEF00D);
    access(1, 1, 0, 2'b11, 32'h8, 32'h302, 0, 3, 32'hA1B2C3D4, 0);
    check("iord_wins", rdata, 32'hA1B2C3D4);
    reset_in_wait();

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      a = $urandom;
      d = $urandom;
      n = $urandom_range(1, 5);
      if (op == 0)
        access(1, 0, 0, 2'($urandom), a, $urandom, d, n, $urandom,
               ($urandom_range(0, 7) == 0));
      else
        access(0, 1, (op == 2), 2'($urandom), $urandom, a, d, n,
               $urandom, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

`ifdef MEMCTRL_TIMEOUT_EN
    access(0, 1, 0, 2'b00, 0, 32'h60, 0, 0, 32'h0, 0);
    #1 check("tmo_err", err, 1);
    check("tmo_mdr", rdata, 0);
    repeat (3) @(negedge clk);
    #1 check("tmo_sticky", err, 1);
`else
    #1 check("err_tied", err, 0);
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    check("mq_drained", memq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
